plateau_frame_detector: RTL and testbench

Downstream consumer of the delay-correlation magnitude stream in the OFDM receive chain. Compares each 21-bit windowed correlation magnitude against a programmable threshold and qualifies a short-preamble plateau: a run of above-threshold samples with bounded dropouts. On a qualified plateau it emits a one-cycle frame-detect pulse, holds a detect flag through a holdoff window, and (optionally) reports the plateau peak for downstream timing fine-sync.

---
 rtl/plateau_frame_detector.sv | 201 ++++++++++++++++++++
 tb/tb_plateau_frame_detector.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plateau_frame_detector.sv
// rtl/plateau_frame_detector.sv - short-preamble plateau qualifier on the correlation magnitude stream
//
// Compares each enabled magnitude sample against a threshold and qualifies a
// plateau: PLATEAU_LEN above-threshold samples, with runs of up to DROP_TOL
// below-threshold samples tolerated. On qualification it pulses o_frame_detect,
// then ignores HOLDOFF_LEN enabled samples while o_detect_flag is high.
//
// Optional feature macro: PLATEAU_PEAK_TRACK_EN (peak magnitude/offset reporting).
//
// Ports:
//   i_clk, i_rst                         clock, asynchronous active-high reset
//   i_input_enable                       magnitude sample valid
//   i_sum_delay_correlation_magnituder   signed 21-bit magnitude (s8.12)
//   i_threshold                          signed 21-bit threshold (s8.12)
//   i_frame_clear                        synchronous abort to IDLE
//   o_output_enable                      i_input_enable delayed one cycle
//   o_frame_detect                       one-cycle pulse on plateau qualification
//   o_detect_flag                        high while in HOLDOFF
//   o_detect_state                       0 = IDLE, 1 = PLATEAU, 2 = HOLDOFF
//   o_peak_magnitude, o_peak_offset      peak of the last qualified plateau
module plateau_frame_detector #(
    parameter int PLATEAU_LEN = 48,
    parameter int DROP_TOL    = 2,
    parameter int HOLDOFF_LEN = 320
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_input_enable,
    input  logic [20:0] i_sum_delay_correlation_magnituder,
    input  logic [20:0] i_threshold,
    input  logic        i_frame_clear,
    output logic        o_output_enable,
    output logic        o_frame_detect,
    output logic        o_detect_flag,
    output logic [1:0]  o_detect_state,
    output logic [20:0] o_peak_magnitude,
    output logic [7:0]  o_peak_offset
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLATEAU = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    localparam logic [7:0] PLAT_LEN_C = 8'(PLATEAU_LEN);
    localparam logic [4:0] DROP_TOL_C = 5'(DROP_TOL);
    localparam logic [9:0] HOLD_LEN_C = 10'(HOLDOFF_LEN);

    state_t      r_state;
    logic [7:0]  r_plat_cnt;
    logic [4:0]  r_drop_cnt;
    logic [9:0]  r_hold_cnt;
    logic        r_output_enable;
    logic        r_frame_detect;
    logic        r_detect_flag;

    logic        w_above;
    logic [7:0]  w_plat_next;
    logic [4:0]  w_drop_next;
    logic [9:0]  w_hold_next;

    // A negative magnitude never counts as above, even against a negative threshold.
    assign w_above = ~i_sum_delay_correlation_magnituder[20] &&
                     ($signed(i_sum_delay_correlation_magnituder) >= $signed(i_threshold));
    assign w_plat_next = r_plat_cnt + 8'd1;
    assign w_drop_next = r_drop_cnt + 5'd1;
    assign w_hold_next = r_hold_cnt + 10'd1;

`ifdef PLATEAU_PEAK_TRACK_EN
    logic [7:0]  r_idx;
    logic [20:0] r_peak_mag;
    logic [7:0]  r_peak_off;
    logic [20:0] r_peak_mag_out;
    logic [7:0]  r_peak_off_out;
    logic [7:0]  w_idx_next;
    logic        w_peak_gt;
    logic [20:0] w_peak_mag_next;
    logic [7:0]  w_peak_off_next;

    // Index runs over every enabled sample since plateau start, drops included.
    assign w_idx_next      = (r_idx == 8'hFF) ? 8'hFF : r_idx + 8'd1;
    // Strictly greater: a tie keeps the earlier sample.
    assign w_peak_gt       = $signed(i_sum_delay_correlation_magnituder) > $signed(r_peak_mag);
    assign w_peak_mag_next = w_peak_gt ? i_sum_delay_correlation_magnituder : r_peak_mag;
    assign w_peak_off_next = w_peak_gt ? w_idx_next : r_peak_off;
    assign o_peak_magnitude = r_peak_mag_out;
    assign o_peak_offset    = r_peak_off_out;
`else
    assign o_peak_magnitude = 21'd0;
    assign o_peak_offset    = 8'd0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state         <= ST_IDLE;
            r_plat_cnt      <= 8'd0;
            r_drop_cnt      <= 5'd0;
            r_hold_cnt      <= 10'd0;
            r_output_enable <= 1'b0;
            r_frame_detect  <= 1'b0;
            r_detect_flag   <= 1'b0;
`ifdef PLATEAU_PEAK_TRACK_EN
            r_idx           <= 8'd0;
            r_peak_mag      <= 21'd0;
            r_peak_off      <= 8'd0;
            r_peak_mag_out  <= 21'd0;
            r_peak_off_out  <= 8'd0;
`endif
        end else begin
            r_output_enable <= i_input_enable;
            r_frame_detect  <= 1'b0;
            if (i_frame_clear) begin
                // Clear beats a qualifying sample in the same cycle; latched peak is kept.
                r_state       <= ST_IDLE;
                r_plat_cnt    <= 8'd0;
                r_drop_cnt    <= 5'd0;
                r_hold_cnt    <= 10'd0;
                r_detect_flag <= 1'b0;
            end else if (i_input_enable) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_above) begin
                            r_drop_cnt <= 5'd0;
                            r_hold_cnt <= 10'd0;
                            if (PLAT_LEN_C == 8'd1) begin
                                // A one-sample plateau qualifies on its first sample.
                                r_state        <= ST_HOLDOFF;
                                r_plat_cnt     <= 8'd0;
                                r_frame_detect <= 1'b1;
                                r_detect_flag  <= 1'b1;
`ifdef PLATEAU_PEAK_TRACK_EN
                                r_peak_mag_out <= i_sum_delay_correlation_magnituder;
                                r_peak_off_out <= 8'd0;
`endif
                            end else begin
                                r_state    <= ST_PLATEAU;
                                r_plat_cnt <= 8'd1;
                            end
`ifdef PLATEAU_PEAK_TRACK_EN
                            r_idx      <= 8'd0;
                            r_peak_mag <= i_sum_delay_correlation_magnituder;
                            r_peak_off <= 8'd0;
`endif
                        end
                    end
                    ST_PLATEAU: begin
`ifdef PLATEAU_PEAK_TRACK_EN
                        r_idx <= w_idx_next;
`endif
                        if (w_above) begin
                            r_drop_cnt <= 5'd0;
`ifdef PLATEAU_PEAK_TRACK_EN
                            r_peak_mag <= w_peak_mag_next;
                            r_peak_off <= w_peak_off_next;
`endif
                            if (w_plat_next == PLAT_LEN_C) begin
                                r_state        <= ST_HOLDOFF;
                                r_plat_cnt     <= 8'd0;
                                r_hold_cnt     <= 10'd0;
                                r_frame_detect <= 1'b1;
                                r_detect_flag  <= 1'b1;
`ifdef PLATEAU_PEAK_TRACK_EN
                                r_peak_mag_out <= w_peak_mag_next;
                                r_peak_off_out <= w_peak_off_next;
`endif
                            end else begin
                                r_plat_cnt <= w_plat_next;
                            end
                        end else if (w_drop_next > DROP_TOL_C) begin
                            r_state    <= ST_IDLE;
                            r_plat_cnt <= 8'd0;
                            r_drop_cnt <= 5'd0;
                        end else begin
                            r_drop_cnt <= w_drop_next;
                        end
                    end
                    ST_HOLDOFF: begin
                        if (w_hold_next == HOLD_LEN_C) begin
                            r_state       <= ST_IDLE;
                            r_hold_cnt    <= 10'd0;
                            r_detect_flag <= 1'b0;
                        end else begin
                            r_hold_cnt <= w_hold_next;
                        end
                    end
                    default: begin
                        r_state       <= ST_IDLE;
                        r_detect_flag <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_output_enable = r_output_enable;
    assign o_frame_detect  = r_frame_detect;
    assign o_detect_flag   = r_detect_flag;
    assign o_detect_state  = r_state;

endmodule

// File: tb/tb_plateau_frame_detector.sv
// tb/tb_plateau_frame_detector.sv - self-checking bench for plateau_frame_detector
module tb_plateau_frame_detector;

    localparam int PL = 48;
    localparam int DT = 2;
    localparam int HL = 320;
    localparam logic [20:0] THR = 21'h00800;
    localparam logic [20:0] HI  = 21'h00A00;
    localparam logic [20:0] LO  = 21'h00100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        clr = 1'b0;
    logic [20:0] mag = 21'd0;
    logic [20:0] thr = THR;

    logic        o_oe, o_fd, o_flag;
    logic [1:0]  o_state;
    logic [20:0] o_pmag;
    logic [7:0]  o_poff;

    always #5 clk = ~clk;

    plateau_frame_detector #(.PLATEAU_LEN(PL), .DROP_TOL(DT), .HOLDOFF_LEN(HL)) dut (
        .i_clk                              (clk),
        .i_rst                              (rst),
        .i_input_enable                     (en),
        .i_sum_delay_correlation_magnituder (mag),
        .i_threshold                        (thr),
        .i_frame_clear                      (clr),
        .o_output_enable                    (o_oe),
        .o_frame_detect                     (o_fd),
        .o_detect_flag                      (o_flag),
        .o_detect_state                     (o_state),
        .o_peak_magnitude                   (o_pmag),
        .o_peak_offset                      (o_poff)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Keeps the list of every enabled sample since plateau start; the peak is
    // found by scanning that list when the plateau qualifies.
    int          m_st, m_run, m_drops, m_hold;
    int          q_mag[$];
    bit          q_ab[$];
    bit          e_oe, e_fd, e_flag;
    logic [1:0]  e_state;
    logic [20:0] e_pmag;
    logic [7:0]  e_poff;

    function automatic int sx(input logic [20:0] v);
        return {{11{v[20]}}, v};
    endfunction

    task automatic model_reset();
        m_st = 0; m_run = 0; m_drops = 0; m_hold = 0;
        q_mag.delete(); q_ab.delete();
        e_oe = 0; e_fd = 0; e_flag = 0; e_state = 2'd0; e_pmag = 21'd0; e_poff = 8'd0;
    endtask

    task automatic model_qualify();
        int best, boff;
        best = -1; boff = 0;
        for (int i = 0; i < q_mag.size(); i++)
            if (q_ab[i] && q_mag[i] > best) begin
                best = q_mag[i];
                boff = (i > 255) ? 255 : i;
            end
`ifdef PLATEAU_PEAK_TRACK_EN
        e_pmag = best[20:0];
        e_poff = boff[7:0];
`endif
        e_fd = 1; m_st = 2; m_hold = 0;
    endtask

    task automatic model_step(input bit s_en, input logic [20:0] s_mag,
                              input logic [20:0] s_thr, input bit s_clr);
        int mv, tv;
        bit ab;
        mv = sx(s_mag);
        tv = sx(s_thr);
        ab = (mv >= 0) && (mv >= tv);
        e_oe = s_en;
        e_fd = 0;
        if (s_clr) begin
            m_st = 0; m_run = 0; m_drops = 0; m_hold = 0;
        end else if (s_en) begin
            case (m_st)
                0: if (ab) begin
                    m_st = 1; m_run = 1; m_drops = 0;
                    q_mag.delete(); q_ab.delete();
                    q_mag.push_back(mv); q_ab.push_back(1'b1);
                    if (PL == 1) model_qualify();
                end
                1: begin
                    q_mag.push_back(mv); q_ab.push_back(ab);
                    if (ab) begin
                        m_run++; m_drops = 0;
                        if (m_run == PL) model_qualify();
                    end else begin
                        m_drops++;
                        if (m_drops > DT) begin m_st = 0; m_run = 0; m_drops = 0; end
                    end
                end
                default: begin
                    m_hold++;
                    if (m_hold == HL) m_st = 0;
                end
            endcase
        end
        e_flag  = (m_st == 2);
        e_state = m_st[1:0];
    endtask

    // Compare process: outputs seen at each falling edge must match the model
    // prediction made at the previous falling edge.
    always @(negedge clk) begin
        if (rst) begin
            model_reset();
            check("reset_ctrl", {27'd0, o_oe, o_fd, o_flag, o_state}, 32'd0);
            check("reset_peak", {3'd0, o_pmag, o_poff}, 32'd0);
        end else begin
            check("cycle_ctrl", {27'd0, o_oe, o_fd, o_flag, o_state},
                                {27'd0, e_oe, e_fd, e_flag, e_state});
            check("cycle_peak", {3'd0, o_pmag, o_poff}, {3'd0, e_pmag, e_poff});
            model_step(en, mag, thr, clr);
        end
    end

    // ---------------- driver with event bookkeeping ----------------
    int sidx, prev_idx, fall_at;
    int fd_q[$];
    bit last_flag;

    task automatic drive(input bit e, input logic [20:0] m, input bit c);
        @(posedge clk);
        #1;
        if (o_fd) fd_q.push_back(prev_idx);
        if (last_flag && !o_flag) fall_at = prev_idx;
        last_flag = o_flag;
        en = e; mag = m; clr = c;
        if (e) begin sidx++; prev_idx = sidx; end
        else prev_idx = 0;
    endtask

    task automatic book_reset();
        sidx = 0; prev_idx = 0; fall_at = -1; last_flag = 0;
        fd_q.delete();
    endtask

    task automatic start_scn();
        thr = THR;
        drive(1'b0, 21'd0, 1'b1);
        drive(1'b0, 21'd0, 1'b0);
        book_reset();
    endtask

    initial begin
        book_reset();
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", {27'd0, o_oe, o_fd, o_flag, o_state}, 32'd0);
        check("rst_peak", {3'd0, o_pmag, o_poff}, 32'd0);
        rst = 1'b0;

        // 48 clean samples, then continued high input through holdoff
        start_scn();
        for (int i = 1; i <= PL; i++) drive(1'b1, HI, 1'b0);
        drive(1'b0, 21'd0, 1'b0);
        check("s1_fd", {31'd0, o_fd}, 32'd1);
        check("s1_flag", {31'd0, o_flag}, 32'd1);
        check("s1_state", {30'd0, o_state}, 32'd2);
        for (int i = 1; i <= HL + PL; i++) drive(1'b1, HI, 1'b0);
        drive(1'b0, 21'd0, 1'b0);
        check("s1_fd_count", fd_q.size(), 32'd2);
        if (fd_q.size() == 2) begin
            check("s1_fd_first", fd_q[0], 32'd48);
            check("s1_fd_second", fd_q[1], 32'd416);
        end
        check("s1_flag_fall", fall_at, 32'd368);

        // Two tolerated drops: detect after 50 samples
        start_scn();
        for (int i = 1; i <= 50; i++) drive(1'b1, (i == 10 || i == 11) ? LO : HI, 1'b0);
        drive(1'b0, 21'd0, 1'b0);
        check("s2_fd_count", fd_q.size(), 32'd1);
        if (fd_q.size() == 1) check("s2_fd_at", fd_q[0], 32'd50);

        // Three drops: back to IDLE at sample 12
        start_scn();
        for (int i = 1; i <= 12; i++) drive(1'b1, (i >= 10) ? LO : HI, 1'b0);
        drive(1'b0, 21'd0, 1'b0);
        check("s3_state", {30'd0, o_state}, 32'd0);
        for (int i = 13; i <= 48; i++) drive(1'b1, HI, 1'b0);
        drive(1'b0, 21'd0, 1'b0);
        check("s3_no_fd", fd_q.size(), 32'd0);

        // Ramp with peak at offset 20 and a tie at offset 30
        start_scn();
        for (int i = 0; i < PL; i++)
            drive(1'b1, (i == 20 || i == 30) ? 21'h01F00 : HI + 21'(i * 16), 1'b0);
        drive(1'b0, 21'd0, 1'b0);
        check("s4_fd", {31'd0, o_fd}, 32'd1);
`ifdef PLATEAU_PEAK_TRACK_EN
        check("s4_peak_mag", {11'd0, o_pmag}, 32'h01F00);
        check("s4_peak_off", {24'd0, o_poff}, 32'd20);
`else
        check("s4_peak_mag", {11'd0, o_pmag}, 32'd0);
        check("s4_peak_off", {24'd0, o_poff}, 32'd0);
`endif

        // FrameClear on sample 48
        start_scn();
        for (int i = 1; i < PL; i++) drive(1'b1, HI, 1'b0);
        drive(1'b1, HI, 1'b1);
        drive(1'b0, 21'd0, 1'b0);
        check("s5_fd", {31'd0, o_fd}, 32'd0);
        check("s5_state", {30'd0, o_state}, 32'd0);

        // Enable every other cycle
        start_scn();
        for (int i = 0; i < 2 * PL; i++) drive((i % 2) == 0, HI, 1'b0);
        drive(1'b0, 21'd0, 1'b0);
        check("s6_fd_count", fd_q.size(), 32'd1);
        if (fd_q.size() == 1) check("s6_fd_at", fd_q[0], 32'd48);

        // Reset at plateau sample 30
        start_scn();
        for (int i = 1; i <= 30; i++) drive(1'b1, HI, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("s7_rst_ctrl", {27'd0, o_oe, o_fd, o_flag, o_state}, 32'd0);
        check("s7_rst_peak", {3'd0, o_pmag, o_poff}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        en = 1'b0;
        book_reset();
        for (int i = 1; i < PL; i++) drive(1'b1, HI, 1'b0);
        drive(1'b0, 21'd0, 1'b0);
        check("s7_no_early_fd", fd_q.size(), 32'd0);
        drive(1'b1, HI, 1'b0);
        drive(1'b0, 21'd0, 1'b0);
        check("s7_fd_count", fd_q.size(), 32'd1);

        // Randomised traffic against the model
        start_scn();
        for (int i = 0; i < 12000; i++) begin
            logic [20:0] m;
            bit e, c;
            if ($urandom_range(0, 199) == 0)
                thr = ($urandom_range(0, 7) == 0) ? 21'h1FF00 + 21'($urandom_range(0, 255))
                                                  : 21'h00700 + 21'($urandom_range(0, 511));
            e = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 1999) == 0);
            case ($urandom_range(0, 19))
                0:       m = thr - 21'($urandom_range(1, 767));
                1:       m = 21'h100000 | 21'($urandom());
                2:       m = thr;
                default: m = thr + 21'($urandom_range(0, 767));
            endcase
            drive(e, m, c);
        end
        drive(1'b0, 21'd0, 1'b0);
        drive(1'b0, 21'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
